// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM encoding, adder
// width and the record holding a granted operation.
package adder_share_arbiter_pkg;

   localparam int ADD_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        wide;
   } op_t;

endpackage

// File: rtl/adder_share_arbiter_ks_adder.sv
// 32-bit Kogge-Stone adder. The carry-in is folded into the bit-0 generate
// term so the prefix tree directly yields every carry including cin.
module ks_adder
   import adder_share_arbiter_pkg::*;
(
   input  logic [ADD_W-1:0] a,
   input  logic [ADD_W-1:0] b,
   input  logic             cin,
   output logic [ADD_W-1:0] sum,
   output logic             cout
);

   localparam int STAGES = $clog2(ADD_W);

   logic [ADD_W-1:0] prop;
   logic [ADD_W-1:0] g_acc;
   logic [ADD_W-1:0] p_acc;

   // Prefix tree: each stage combines (g,p) with the pair 2^s bits below;
   // bits with no partner below keep their propagate unchanged.
   always_comb begin
      prop     = a ^ b;
      g_acc    = a & b;
      g_acc[0] = g_acc[0] | (prop[0] & cin);
      p_acc    = prop;
      for (int s = 0; s < STAGES; s++) begin
         g_acc = g_acc | (p_acc & (g_acc << (1 << s)));
         p_acc = p_acc & ((p_acc << (1 << s)) | ((ADD_W'(1) << (1 << s)) - ADD_W'(1)));
      end
      sum  = prop ^ {g_acc[ADD_W-2:0], cin};
      cout = g_acc[ADD_W-1];
   end

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin grant: the search starts one past the previous winner and the
// nearest requesting index wins. Output is one-hot, or zero with no request.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant
);

   int idx;

   // Scan from the farthest candidate to the nearest so the nearest hit
   // overwrites any earlier one.
   always_comb begin
      grant = '0;
      idx   = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Several requesters share one 32-bit adder. A granted operation runs one
// pass (narrow) or two passes (wide, low half then high half with the carry
// held in between) and the result is held until the consumer takes it.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [64*NREQ-1:0] req_a,
   input  logic [64*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   input  logic [NREQ-1:0]   req_wide,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [63:0]       rsp_sum,
   output logic              rsp_cout
);

   logic [1:0]       state;
   logic [IDW-1:0]   last_grant;
   logic [IDW-1:0]   grant_idx;
   logic [NREQ-1:0]  grant;
   op_t              op_q;
   op_t              sel_op;
   logic             carry_q;
   logic [31:0]      sum_lo;
   logic [31:0]      sum_hi;
   logic [ADD_W-1:0] add_a;
   logic [ADD_W-1:0] add_b;
   logic             add_cin;
   logic [ADD_W-1:0] add_sum;
   logic             add_cout;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   ks_adder u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Turn the one-hot grant into an index and pick that requester's operands.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) grant_idx = IDW'(i);
      end
      sel_op.a    = req_a[64*int'(grant_idx) +: 64];
      sel_op.b    = req_b[64*int'(grant_idx) +: 64];
      sel_op.cin  = req_cin[grant_idx];
      sel_op.wide = req_wide[grant_idx];
   end

   // The adder sees the high halves and the stored carry only in HI.
   always_comb begin
      if (state == ST_HI) begin
         add_a   = op_q.a[63:32];
         add_b   = op_q.b[63:32];
         add_cin = carry_q;
      end else begin
         add_a   = op_q.a[31:0];
         add_b   = op_q.b[31:0];
         add_cin = op_q.cin;
      end
   end

   // Accept strobe only while idle; reset masks it immediately.
   assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
   assign rsp_valid = (state == ST_DONE);
   assign rsp_sum   = {sum_hi, sum_lo};
   assign rsp_cout  = carry_q;

   // Operation sequencer: grant and latch, low pass, optional high pass,
   // then hold the result until it is consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= IDW'(NREQ-1);
         op_q       <= '0;
         rsp_id     <= '0;
         carry_q    <= 1'b0;
         sum_lo     <= '0;
         sum_hi     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  op_q       <= sel_op;
                  rsp_id     <= grant_idx;
                  last_grant <= grant_idx;
                  sum_hi     <= '0;
                  state      <= ST_LO;
               end
            end
            ST_LO: begin
               sum_lo  <= add_sum;
               carry_q <= add_cout;
               state   <= op_q.wide ? ST_HI : ST_DONE;
            end
            ST_HI: begin
               sum_hi  <= add_sum;
               carry_q <= add_cout;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_adder_share_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [64*NREQ-1:0]  req_a;
   logic [64*NREQ-1:0]  req_b;
   logic [NREQ-1:0]     req_cin;
   logic [NREQ-1:0]     req_wide;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [63:0]         rsp_sum;
   logic                rsp_cout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_wide  (req_wide),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
   );

   // Free-running clock and cycle counter used for latency bookkeeping.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic wide);
      req_a[64*idx +: 64] = a;
      req_b[64*idx +: 64] = b;
      req_cin[idx]        = cin;
      req_wide[idx]       = wide;
      req_valid[idx]      = 1'b1;
   endtask

   // Wait (bounded) for requester idx to be accepted, then drop its request.
   task automatic waitGrant(input int idx, output int acc_cyc);
      bit seen = 0;
      acc_cyc = cyc;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            seen    = 1;
            acc_cyc = cyc;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL grant timeout: requester %0d never accepted", idx);
      end
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid; returns at the negedge where it is seen.
   task automatic waitRsp(output int rsp_cyc);
      bit seen = 0;
      rsp_cyc = cyc;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen    = 1;
            rsp_cyc = cyc;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL response timeout: rsp_valid never rose");
      end
   endtask

   function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [63:0] randOperand();
      case ($urandom_range(0, 3))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'h0000_0000_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Reference model: one outstanding operation at most, result known at
   // accept time from plain arithmetic, visible from accept+2 (narrow) or
   // accept+3 (wide) until consumed. Compared on every negedge.
   initial begin : model
      bit              m_busy;
      int              m_last;
      int              m_ready_cyc;
      int              m_id;
      logic [63:0]     m_sum;
      logic            m_cout;
      logic [NREQ-1:0] exp_ready;
      bit              exp_valid;
      int              pick;
      logic [64:0]     full;
      logic [32:0]     nar;
      logic [63:0]     a;
      logic [63:0]     b;
      m_busy      = 0;
      m_last      = NREQ - 1;
      m_ready_cyc = 0;
      m_id        = 0;
      m_sum       = '0;
      m_cout      = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            checkOutput("reset req_ready", 64'(req_ready), 64'h0);
            checkOutput("reset rsp_valid", 64'(rsp_valid), 64'h0);
            checkOutput("reset rsp_id",    64'(rsp_id),    64'h0);
            checkOutput("reset rsp_sum",   rsp_sum,        64'h0);
            checkOutput("reset rsp_cout",  64'(rsp_cout),  64'h0);
            m_busy = 0;
            m_last = NREQ - 1;
         end else begin
            exp_valid = m_busy && (cyc >= m_ready_cyc);
            pick      = m_busy ? -1 : rrPick(req_valid, m_last);
            exp_ready = '0;
            if (pick >= 0) exp_ready[pick] = 1'b1;
            checkOutput("model req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("model rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid) begin
               checkOutput("model rsp_id",   64'(rsp_id),   64'(m_id));
               checkOutput("model rsp_sum",  rsp_sum,       m_sum);
               checkOutput("model rsp_cout", 64'(rsp_cout), 64'(m_cout));
               if (rsp_ready) m_busy = 0;
            end
            if (pick >= 0) begin
               a = req_a[64*pick +: 64];
               b = req_b[64*pick +: 64];
               if (req_wide[pick]) begin
                  full   = {1'b0, a} + {1'b0, b} + 65'(req_cin[pick]);
                  m_sum  = full[63:0];
                  m_cout = full[64];
               end else begin
                  nar    = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(req_cin[pick]);
                  m_sum  = {32'h0, nar[31:0]};
                  m_cout = nar[32];
               end
               m_id        = pick;
               m_busy      = 1;
               m_last      = pick;
               m_ready_cyc = cyc + (req_wide[pick] ? 3 : 2);
            end
         end
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin : stim
      int acc;
      int rc;
      int gq[$];
      int rq[$];
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};

      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_wide  = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset gate req_ready", 64'(req_ready), 64'h0);
      checkOutput("reset rsp_valid lit",  64'(rsp_valid), 64'h0);
      checkOutput("reset rsp_sum lit",    rsp_sum,        64'h0);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst       = 1'b0;

      // Narrow wrap to zero with carry-out, requester 0 first after reset.
      applyStimulus(0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      waitGrant(0, acc);
      waitRsp(rc);
      checkOutput("narrow latency", 64'(rc - acc), 64'd2);
      checkOutput("narrow id",      64'(rsp_id),   64'd0);
      checkOutput("narrow sum",     rsp_sum,       64'h0);
      checkOutput("narrow cout",    64'(rsp_cout), 64'd1);
      @(posedge clk);
      #1;

      // Wide: carry crosses from the low pass into the high pass.
      applyStimulus(2, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
      waitGrant(2, acc);
      waitRsp(rc);
      checkOutput("wide latency", 64'(rc - acc), 64'd3);
      checkOutput("wide id",      64'(rsp_id),   64'd2);
      checkOutput("wide sum",     rsp_sum,       64'h0000_0001_0000_0000);
      checkOutput("wide cout",    64'(rsp_cout), 64'd0);
      @(posedge clk);
      #1;

      // Wide overflow: all ones plus all ones plus carry-in.
      applyStimulus(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      waitGrant(3, acc);
      waitRsp(rc);
      checkOutput("overflow id",   64'(rsp_id),   64'd3);
      checkOutput("overflow sum",  rsp_sum,       64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("overflow cout", 64'(rsp_cout), 64'd1);
      @(posedge clk);
      #1;

      // Fairness: everyone requesting continuously.
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 64'(i * 16), 64'h1, 1'b0, 1'b0);
      for (int k = 0; k < 80 && rq.size() < 5; k++) begin
         @(negedge clk);
         for (int j = 0; j < NREQ; j++) if (req_ready[j]) gq.push_back(j);
         if (rsp_valid) rq.push_back(int'(rsp_id));
      end
      if (gq.size() < 5 || rq.size() < 5) begin
         checks++;
         failures++;
         $display("[TB] FAIL fairness timeout: grants=%0d responses=%0d", gq.size(), rq.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("fair grant %0d", k), 64'(gq[k]), 64'(exp_order[k]));
            checkOutput($sformatf("fair rsp_id %0d", k), 64'(rq[k]), 64'(exp_order[k]));
         end
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (6) @(posedge clk);
      #1;

      // Backpressure: result held while the consumer stalls.
      rsp_ready = 1'b0;
      applyStimulus(1, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0);
      waitGrant(1, acc);
      applyStimulus(2, 64'd5, 64'd7, 1'b1, 1'b0);
      waitRsp(rc);
      checkOutput("bp sum", rsp_sum, 64'h2345_6789);
      checkOutput("bp id",  64'(rsp_id), 64'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("bp hold valid",     64'(rsp_valid), 64'd1);
         checkOutput("bp hold sum",       rsp_sum,        64'h2345_6789);
         checkOutput("bp hold id",        64'(rsp_id),    64'd1);
         checkOutput("bp hold req_ready", 64'(req_ready), 64'h0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp release valid", 64'(rsp_valid), 64'd1);
      waitGrant(2, acc);
      waitRsp(rc);
      checkOutput("bp next sum", rsp_sum, 64'd13);
      checkOutput("bp next id",  64'(rsp_id), 64'd2);
      @(posedge clk);
      #1;

      // Reset while in the high pass: no response, arbitration restarts.
      applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
      waitGrant(1, acc);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 64'(i + 1), 64'h2, 1'b0, 1'b0);
      #1;
      checkOutput("rst HI rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst HI req_ready", 64'(req_ready), 64'h0);
      checkOutput("rst HI rsp_sum",   rsp_sum,        64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset grant", 64'(req_ready), 64'h1);
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (6) @(posedge clk);
      #1;

      // Asynchronous reset while holding a result.
      rsp_ready = 1'b0;
      applyStimulus(2, 64'hFFFF_FFFF, 64'h3, 1'b0, 1'b0);
      waitGrant(2, acc);
      waitRsp(rc);
      checkOutput("done sum", rsp_sum, 64'h2);
      checkOutput("done cout", 64'(rsp_cout), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("async rst rsp_id",    64'(rsp_id),    64'd0);
      checkOutput("async rst rsp_sum",   rsp_sum,        64'h0);
      checkOutput("async rst rsp_cout",  64'(rsp_cout),  64'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("no rsp after reset", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;

      // Randomized traffic with operands changing every cycle.
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 249) == 0);
         req_valid = 4'($urandom);
         for (int j = 0; j < NREQ; j++) begin
            req_a[64*j +: 64] = randOperand();
            req_b[64*j +: 64] = randOperand();
            req_cin[j]        = 1'($urandom);
            req_wide[j]       = 1'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
